// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC QR result path.
//   MATRIX_INT / DEC_PT : fixed-point split of a result word
//   DATA_W              : result word width (integer + fraction + sign-ext bit)
//   ROWS / COLS         : result frame geometry, FRAME_WORDS words per frame
//   word_t              : one result word
//   rd_state_t          : read-side FSM states of the collector
package cordic_pkg;

  localparam int MATRIX_INT  = 8;
  localparam int DEC_PT      = 3;
  localparam int DATA_W      = MATRIX_INT + DEC_PT + 1;
  localparam int ROWS        = 4;
  localparam int COLS        = 4;
  localparam int FRAME_WORDS = ROWS * COLS;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {
    IDLE,
    SEND
  } rd_state_t;

endpackage

// File: rtl/result_bank.sv
// One frame of result storage.
//   clk      : write clock
//   wr_en    : store wr_data at wr_addr (row-major word index)
//   wr_addr  : word index 0 .. ROWS*COLS-1
//   wr_data  : word to store
//   rd_row   : row to present on rd_data
//   rd_data  : COLS words of row rd_row, lane c = column c
// Storage carries no reset; the collector qualifies reads with its own
// valid state, so stale contents are never observed.
module result_bank #(
  parameter int DATA_W = cordic_pkg::DATA_W,
  parameter int ROWS   = cordic_pkg::ROWS,
  parameter int COLS   = cordic_pkg::COLS
) (
  input  logic                               clk,
  input  logic                               wr_en,
  input  logic [$clog2(ROWS*COLS)-1:0]       wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  input  logic [$clog2(ROWS)-1:0]            rd_row,
  output logic [COLS-1:0][DATA_W-1:0]        rd_data
);

  localparam int ADDR_W = $clog2(ROWS*COLS);
  localparam int RIDX_W = $clog2(ROWS);

  logic [COLS-1:0][DATA_W-1:0] mem [ROWS];

  // Row-major address decode written as a compare per cell so the
  // word index never has to be split into row/column fields.
  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (wr_en && (wr_addr == ADDR_W'(r*COLS + c))) begin
          mem[r][c] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (rd_row == RIDX_W'(r)) begin
        rd_data = mem[r];
      end
    end
  end

endmodule

// File: rtl/cordic_result_collector.sv
// Receiving end of the CORDIC QR core's result stream. Serial result words
// are reassembled into ROWS x COLS frames (row-major) in two frame banks and
// presented one row per valid/ready transfer. The core cannot be stalled, so
// words that arrive while both banks hold unread frames are dropped.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   res_valid       : qualifies res_data (core out_valid)
//   res_data        : one result word (core out_matrix)
//   row_valid       : a row is presented on row_0..row_3
//   row_ready       : consumer accepts the row when row_valid && row_ready
//   row_0..row_3    : columns 0..3 of the current row
//   row_idx         : row number within the frame
//   frame_done      : high in the cycle the last row of a frame is accepted
//   err_overflow    : sticky, a word was dropped with both banks full
//   err_timeout     : one-cycle pulse when a stalled partial frame is discarded
//
// Build option: define COLLECTOR_TIMEOUT_EN to discard partial frames that
// sit idle for TIMEOUT_CYC cycles; otherwise err_timeout is tied low.
module cordic_result_collector #(
  parameter int DATA_W      = cordic_pkg::DATA_W,
  parameter int ROWS        = cordic_pkg::ROWS,
  parameter int COLS        = cordic_pkg::COLS,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      res_valid,
  input  logic [DATA_W-1:0]         res_data,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic [DATA_W-1:0]         row_0,
  output logic [DATA_W-1:0]         row_1,
  output logic [DATA_W-1:0]         row_2,
  output logic [DATA_W-1:0]         row_3,
  output logic [$clog2(ROWS)-1:0]   row_idx,
  output logic                      frame_done,
  output logic                      err_overflow,
  output logic                      err_timeout
);

  import cordic_pkg::*;

  localparam int FRAME  = ROWS * COLS;
  localparam int CNT_W  = $clog2(FRAME);
  localparam int RIDX_W = $clog2(ROWS);

  if (COLS != 4) begin : g_bad_cols
    $error("row_0..row_3 expose exactly four lanes; COLS must be 4");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  rd_state_t                  state, state_nxt;
  logic [1:0]                 bank_full, full_nxt;
  logic                       wr_bank;
  logic                       rd_bank, rd_bank_nxt;
  logic [CNT_W-1:0]           wr_cnt;
  logic [RIDX_W-1:0]          row_idx_nxt;

  logic                       hs, last_row, free_now;
  logic                       target_full, wr_accept, wr_drop, frame_cmpl;
  logic                       timeout_hit;

  logic [COLS-1:0][DATA_W-1:0] rd_data0, rd_data1, rd_sel;

  assign hs       = (state == SEND) && row_ready;
  assign last_row = (row_idx == RIDX_W'(ROWS-1));
  assign free_now = hs && last_row;

  // A bank released by the reader this cycle counts as empty for the writer.
  assign target_full = bank_full[wr_bank] && !(free_now && (rd_bank == wr_bank));
  assign wr_accept   = res_valid && !target_full;
  assign wr_drop     = res_valid && target_full;
  assign frame_cmpl  = wr_accept && (wr_cnt == CNT_W'(FRAME-1));

  always_comb begin
    full_nxt = bank_full;
    if (free_now)   full_nxt[rd_bank] = 1'b0;
    if (frame_cmpl) full_nxt[wr_bank] = 1'b1;
  end

  // ---------------------------------------------------------------- banks
  result_bank #(
    .DATA_W (DATA_W),
    .ROWS   (ROWS),
    .COLS   (COLS)
  ) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_accept && (wr_bank == 1'b0)),
    .wr_addr (wr_cnt),
    .wr_data (res_data),
    .rd_row  (row_idx),
    .rd_data (rd_data0)
  );

  result_bank #(
    .DATA_W (DATA_W),
    .ROWS   (ROWS),
    .COLS   (COLS)
  ) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_accept && (wr_bank == 1'b1)),
    .wr_addr (wr_cnt),
    .wr_data (res_data),
    .rd_row  (row_idx),
    .rd_data (rd_data1)
  );

  // ----------------------------------------------------------- write side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full    <= '0;
      wr_bank      <= 1'b0;
      wr_cnt       <= '0;
      err_overflow <= 1'b0;
    end else begin
      bank_full <= full_nxt;
      if (wr_drop) begin
        err_overflow <= 1'b1;
      end
      if (wr_accept) begin
        if (frame_cmpl) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + CNT_W'(1);
        end
      end else if (timeout_hit) begin
        wr_cnt <= '0;
      end
    end
  end

`ifdef COLLECTOR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] idle_cnt;

  // Fires on the TIMEOUT_CYC-th consecutive idle cycle of a partial frame.
  assign timeout_hit = !res_valid && (wr_cnt != '0) &&
                       (idle_cnt == TO_W'(TIMEOUT_CYC-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_hit;
      if (res_valid || timeout_hit) begin
        idle_cnt <= '0;
      end else if (wr_cnt != '0) begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // ------------------------------------------------------------ read side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      row_idx <= '0;
    end else begin
      state   <= state_nxt;
      rd_bank <= rd_bank_nxt;
      row_idx <= row_idx_nxt;
    end
  end

  // Looking at full_nxt lets a frame completing this cycle start SEND on the
  // very next cycle, and lets back-to-back frames stream without a bubble.
  always_comb begin
    state_nxt   = state;
    rd_bank_nxt = rd_bank;
    row_idx_nxt = row_idx;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (full_nxt[rd_bank]) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (last_row) begin
            frame_done  = 1'b1;
            rd_bank_nxt = ~rd_bank;
            row_idx_nxt = '0;
            state_nxt   = full_nxt[~rd_bank] ? SEND : IDLE;
          end else begin
            row_idx_nxt = row_idx + RIDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign row_valid = (state == SEND);
  assign rd_sel    = rd_bank ? rd_data1 : rd_data0;

  always_comb begin
    row_0 = '0;
    row_1 = '0;
    row_2 = '0;
    row_3 = '0;
    if (state == SEND) begin
      row_0 = rd_sel[0];
      row_1 = rd_sel[1];
      row_2 = rd_sel[2];
      row_3 = rd_sel[3];
    end
  end

endmodule

// File: tb/tb_cordic_result_collector.sv
module tb_cordic_result_collector;
  import cordic_pkg::*;

  localparam int TIMEOUT_CYC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  word_t       res_data;
  logic        row_valid;
  logic        row_ready;
  word_t       row_0, row_1, row_2, row_3;
  logic [1:0]  row_idx;
  logic        frame_done;
  logic        err_overflow;
  logic        err_timeout;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: queue of complete unread frames (flattened, row-major),
  // the partial frame being received, and the reader's row position.
  word_t frames[$];
  word_t partial[$];
  int    rd_row   = 0;
  bit    ovf      = 1'b0;
  int    idle     = 0;
  bit    to_pend  = 1'b0;
  int    held     = 0;

  cordic_result_collector #(
    .DATA_W      (DATA_W),
    .ROWS        (ROWS),
    .COLS        (COLS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .row_0        (row_0),
    .row_1        (row_1),
    .row_2        (row_2),
    .row_3        (row_3),
    .row_idx      (row_idx),
    .frame_done   (frame_done),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    frames.delete();
    partial.delete();
    rd_row  = 0;
    ovf     = 1'b0;
    idle    = 0;
    to_pend = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs at negedge, advance model.
  task automatic step(input bit v, input word_t d, input bit rdy);
    bit exp_valid;
    res_valid = v;
    res_data  = d;
    row_ready = rdy;
    @(negedge clk);
    exp_valid = (frames.size() >= FRAME_WORDS);
    check("row_valid", {31'd0, row_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      check("row_idx", {30'd0, row_idx}, rd_row);
      check("row_0", {20'd0, row_0}, {20'd0, frames[rd_row*COLS + 0]});
      check("row_1", {20'd0, row_1}, {20'd0, frames[rd_row*COLS + 1]});
      check("row_2", {20'd0, row_2}, {20'd0, frames[rd_row*COLS + 2]});
      check("row_3", {20'd0, row_3}, {20'd0, frames[rd_row*COLS + 3]});
    end
    check("frame_done", {31'd0, frame_done},
          {31'd0, exp_valid && rdy && (rd_row == ROWS-1)});
    check("err_overflow", {31'd0, err_overflow}, {31'd0, ovf});
    check("err_timeout", {31'd0, err_timeout}, {31'd0, to_pend});

    // read side first: a freed bank is usable by this cycle's write
    if (exp_valid && rdy) begin
      if (rd_row == ROWS-1) begin
        for (int i = 0; i < FRAME_WORDS; i++) void'(frames.pop_front());
        rd_row = 0;
      end else begin
        rd_row++;
      end
    end
    to_pend = 1'b0;
    if (v) begin
      idle = 0;
      if (frames.size() >= 2*FRAME_WORDS) begin
        ovf = 1'b1;
      end else begin
        partial.push_back(d);
        if (partial.size() == FRAME_WORDS) begin
          foreach (partial[i]) frames.push_back(partial[i]);
          partial.delete();
        end
      end
    end else begin
`ifdef COLLECTOR_TIMEOUT_EN
      if (partial.size() > 0) begin
        idle++;
        if (idle == TIMEOUT_CYC) begin
          partial.delete();
          idle    = 0;
          to_pend = 1'b1;
        end
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".row_valid"},    {31'd0, row_valid},    32'd0);
    check({tag, ".row_0"},        {20'd0, row_0},        32'd0);
    check({tag, ".row_1"},        {20'd0, row_1},        32'd0);
    check({tag, ".row_2"},        {20'd0, row_2},        32'd0);
    check({tag, ".row_3"},        {20'd0, row_3},        32'd0);
    check({tag, ".row_idx"},      {30'd0, row_idx},      32'd0);
    check({tag, ".frame_done"},   {31'd0, frame_done},   32'd0);
    check({tag, ".err_overflow"}, {31'd0, err_overflow}, 32'd0);
    check({tag, ".err_timeout"},  {31'd0, err_timeout},  32'd0);
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
  endtask

  initial begin
    word_t w;
    rst       = 1'b1;
    res_valid = 1'b0;
    res_data  = '0;
    row_ready = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single frame 0x001..0x010, consumer always ready
    for (int i = 1; i <= FRAME_WORDS; i++) begin
      w = word_t'(i);
      step(1'b1, w, 1'b1);
    end
    idle_cycles(6, 1'b1);

    // Back-pressure: hold row 1 for five cycles
    held = 0;
    for (int i = 0; i < FRAME_WORDS + 14; i++) begin
      bit rdy;
      rdy = 1'b1;
      if (frames.size() >= FRAME_WORDS && rd_row == 1 && held < 5) begin
        rdy = 1'b0;
        held++;
      end
      if (i < FRAME_WORDS) step(1'b1, word_t'($urandom), rdy);
      else                 step(1'b0, '0, rdy);
    end

    // Gapped input: valid every other cycle
    for (int i = 0; i < 2*FRAME_WORDS; i++) begin
      step(i % 2 == 0, word_t'($urandom), 1'b1);
    end
    idle_cycles(6, 1'b1);

    // Overflow: three back-to-back frames while the consumer stalls
    for (int i = 0; i < 3*FRAME_WORDS; i++) begin
      step(1'b1, word_t'($urandom), 1'b0);
    end
    idle_cycles(3, 1'b0);
    idle_cycles(12, 1'b1);

    // Reset mid-frame after seven words
    for (int i = 0; i < 7; i++) step(1'b1, word_t'($urandom), 1'b1);
    rst = 1'b1;
    #2;
    check_all_zero("midreset");
    model_reset();
    res_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < FRAME_WORDS; i++) step(1'b1, word_t'($urandom), 1'b1);
    idle_cycles(6, 1'b1);

`ifdef COLLECTOR_TIMEOUT_EN
    // Stalled partial frame is discarded; next frame starts at word 0
    for (int i = 0; i < 5; i++) step(1'b1, word_t'($urandom), 1'b1);
    idle_cycles(TIMEOUT_CYC + 3, 1'b1);
    for (int i = 0; i < FRAME_WORDS; i++) step(1'b1, word_t'($urandom), 1'b1);
    idle_cycles(6, 1'b1);
`endif

    // Randomized traffic, including simultaneous free/write and overflow
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, word_t'($urandom), $urandom_range(0, 2) != 0);
    end
    idle_cycles(3*FRAME_WORDS, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
